// File: rtl/csa_mul_seq.sv
// csa_mul_seq -- sequential unsigned multiplier built around a 4:2 carry-save
// compressor. Each COMP cycle folds two partial products (radix-4) into a
// redundant 2*WIDTH accumulator (sum_r, carry_r). A single RESOLVE cycle then
// adds the two halves into the registered product.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   operand pair offered
//   in_ready   operands accepted (IDLE only)
//   in_a       multiplicand, unsigned, WIDTH bits
//   in_b       multiplier, unsigned, WIDTH bits
//   out_valid  product available (DONE only)
//   out_ready  consumer takes product
//   out_p      product a*b, 2*WIDTH bits, held until the next RESOLVE
//   busy       high in COMP or RESOLVE
//
// Build option: define CSA_MUL_EARLY_TERM_EN to leave COMP as soon as the
// remaining multiplier bits are all zero. Results are identical either way;
// only latency changes.
module csa_mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_p,
  output logic                 busy
);

  localparam int PW    = 2 * WIDTH;
  localparam int STEPS = WIDTH / 2;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

  typedef enum logic [1:0] {IDLE, COMP, RESOLVE, DONE} state_t;

  state_t           state;
  logic [PW-1:0]    sum_r;
  logic [PW-1:0]    carry_r;
  logic [PW-1:0]    a_sh;     // multiplicand, pre-shifted to the current digit
  logic [WIDTH-1:0] b_sh;     // multiplier, consumed two bits per step
  logic [CNT_W-1:0] cnt;

  logic [PW-1:0]    pp0;
  logic [PW-1:0]    pp1;
  logic [PW-1:0]    nxt_sum;
  logic [PW-1:0]    nxt_carry;
  logic             last_step;

  // 4:2 compressor with zero carry-in. The first full-adder row's carries
  // feed the second row one bit up; anything pushed past the top bit is
  // dropped, which is safe because the final product fits in PW bits.
  function automatic logic [2*PW-1:0] compress42(
    input logic [PW-1:0] x1,
    input logic [PW-1:0] x2,
    input logic [PW-1:0] x3,
    input logic [PW-1:0] x4
  );
    logic [PW-1:0] s1, cout, cin, s, c;
    s1   = x1 ^ x2 ^ x3;
    cout = (x1 & x2) | (x1 & x3) | (x2 & x3);
    cin  = cout << 1;
    s    = s1 ^ x4 ^ cin;
    c    = ((s1 & x4) | (s1 & cin) | (x4 & cin)) << 1;
    return {s, c};
  endfunction

  function automatic logic [PW-1:0] resolve_sum(
    input logic [PW-1:0] s,
    input logic [PW-1:0] c
  );
    return s + c;
  endfunction

  always_comb begin
    pp0 = b_sh[0] ? a_sh : '0;
    pp1 = b_sh[1] ? (a_sh << 1) : '0;
    {nxt_sum, nxt_carry} = compress42(sum_r, carry_r, pp0, pp1);
`ifdef CSA_MUL_EARLY_TERM_EN
    // b_sh[WIDTH-1:2] holds the original multiplier bits above this digit.
    last_step = (cnt == LAST) || (b_sh[WIDTH-1:2] == '0);
`else
    last_step = (cnt == LAST);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      sum_r   <= '0;
      carry_r <= '0;
      a_sh    <= '0;
      b_sh    <= '0;
      cnt     <= '0;
      out_p   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh    <= {{WIDTH{1'b0}}, in_a};
            b_sh    <= in_b;
            sum_r   <= '0;
            carry_r <= '0;
            cnt     <= '0;
            state   <= COMP;
          end
        end
        COMP: begin
          sum_r   <= nxt_sum;
          carry_r <= nxt_carry;
          a_sh    <= a_sh << 2;
          b_sh    <= b_sh >> 2;
          cnt     <= cnt + 1'b1;
          if (last_step) state <= RESOLVE;
        end
        RESOLVE: begin
          out_p <= resolve_sum(sum_r, carry_r);
          state <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == COMP) || (state == RESOLVE);

endmodule

// File: tb/tb_csa_mul_seq.sv
// Testbench for csa_mul_seq: directed cases followed by randomized operands,
// each product and latency compared against a plain arithmetic reference.
module tb_csa_mul_seq;

  localparam int WIDTH = 32;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_a;
  logic [WIDTH-1:0]     in_b;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   out_p;
  logic                 busy;

  int n_assert = 0;
  int n_fail   = 0;

  csa_mul_seq #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Cycles from the fire cycle to the first cycle with out_valid high.
  function automatic int exp_latency(input logic [31:0] b);
    int bl;
    int steps;
    bl = 0;
    for (int i = 0; i < WIDTH; i++) if (b[i]) bl = i + 1;
`ifdef CSA_MUL_EARLY_TERM_EN
    steps = (bl == 0) ? 1 : (bl + 1) / 2;
`else
    steps = (bl >= 0) ? WIDTH / 2 : 0;
`endif
    return steps + 2;
  endfunction

  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input int stall, input bit poke);
    int          cyc;
    logic [63:0] exp;
    exp = 64'(a) * 64'(b);
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    @(negedge clk);
    cyc      = 1;
    in_valid = 1'b0;
    in_a     = $urandom;
    in_b     = $urandom;
    chk("busy_after_fire", busy, 1);
    while (!out_valid && cyc < 100) begin
      if (poke && cyc == 2) begin
        in_valid = 1'b1;
        chk("in_ready_while_busy", in_ready, 0);
      end
      @(negedge clk);
      cyc++;
      in_valid = 1'b0;
    end
    chk("latency", 64'(cyc), 64'(exp_latency(b)));
    chk("product", out_p, exp);
    for (int i = 0; i < stall; i++) begin
      in_valid = i[0];
      @(negedge clk);
      chk("stall_valid", out_valid, 1);
      chk("stall_product", out_p, exp);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("idle_ready", in_ready, 1);
    chk("idle_valid", out_valid, 0);
    chk("held_product", out_p, exp);
  endtask

  initial begin
    bit          seen;
    logic [31:0] ra;
    logic [31:0] rb;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_a      = '0;
    in_b      = '0;
    repeat (2) @(negedge clk);
    in_valid = 1'b1;
    in_a     = 32'd7;
    in_b     = 32'd9;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_p", out_p, 0);
    in_valid = 1'b0;
    rst      = 1'b0;

    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
    run_op(32'd3, 32'd5, 1, 1'b0);
    run_op(32'h1234_5678, 32'd0, 2, 1'b1);
    run_op(32'd0, 32'hDEAD_BEEF, 0, 1'b0);
    run_op($urandom, $urandom, 10, 1'b0);

    // Abort mid-COMP: reset during step 5 must drop the operation.
    @(negedge clk);
    in_valid = 1'b1;
    in_a     = 32'hCAFE_F00D;
    in_b     = 32'hFFFF_FFFF;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("abort_busy_before", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_busy", busy, 0);
    chk("abort_out_p", out_p, 0);
    seen = 1'b0;
    repeat (25) begin
      @(negedge clk);
      seen |= out_valid;
    end
    chk("abort_no_valid", seen, 0);
    run_op(32'h0001_0003, 32'h0000_0101, 0, 1'b0);

    for (int n = 0; n < 2000; n++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      run_op(ra, rb, $urandom_range(0, 3), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
